// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states and requester IDs.
package sram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Wide enough for MAX_LOCK up to 15.
  localparam int unsigned LOCK_CNT_W = 4;

endpackage

// File: rtl/rr_lock_picker.sv
// Combinational winner select: single requester wins outright; on a tie the
// lock keeps D, otherwise the port that did not win last time goes next.
module rr_lock_picker
  import sram_arb_pkg::*;
(
  input  logic  eligible_c_i,
  input  logic  eligible_d_i,
  input  port_e last_winner_i,
  input  logic  lock_active_i,
  output logic  any_eligible_o,
  output port_e winner_o
);

  assign any_eligible_o = eligible_c_i | eligible_d_i;

  // NOTE: assign every always_comb output before any branch so no path can leave it unassigned and infer a latch.
  always_comb begin
    winner_o = PORT_C;
    if (eligible_c_i && eligible_d_i) begin
      if (lock_active_i) begin
        winner_o = PORT_D;
      end else begin
        winner_o = (last_winner_i == PORT_C) ? PORT_D : PORT_C;
      end
    end else if (eligible_d_i) begin
      winner_o = PORT_D;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM: registered request/grant,
// one-cycle ACCESS per grant, round-robin with a bounded D lock and bootstrap override.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              bootstrapping,

  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              sram_write_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data,
  output logic              busy
);

  state_e                state_q, state_d;
  port_e                 winner_q, winner_d;
  port_e                 last_q, last_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  c_rvalid_q, c_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]     c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;

  logic  eligible_c, eligible_d, lock_active, any_eligible;
  port_e pick;

  assign eligible_c  = c_req & ~bootstrapping;
  assign eligible_d  = d_req;
  assign lock_active = (last_q == PORT_D) && d_lock && d_req &&
                       (lock_cnt_q < LOCK_CNT_W'(MAX_LOCK));

  rr_lock_picker u_picker (
    .eligible_c_i   (eligible_c),
    .eligible_d_i   (eligible_d),
    .last_winner_i  (last_q),
    .lock_active_i  (lock_active),
    .any_eligible_o (any_eligible),
    .winner_o       (pick)
  );

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    c_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    c_rdata_d  = c_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_eligible) begin
          state_d  = ACCESS;
          winner_d = pick;
          if (pick == PORT_C) begin
            we_d       = c_we;
            addr_d     = c_addr;
            wdata_d    = c_wdata;
            lock_cnt_d = '0;
          end else begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            // Only D wins that starve a waiting C count against the lock budget.
            if (eligible_c) lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
          end
        end
      end
      ACCESS: begin
        state_d = IDLE;
        last_d  = winner_q;
        if (!we_q) begin
          if (winner_q == PORT_C) begin
            c_rvalid_d = 1'b1;
            c_rdata_d  = sram_read_data;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = sram_read_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bootstrapping || !d_lock) lock_cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      winner_q   <= PORT_C;
      last_q     <= PORT_D;
      lock_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // The SRAM bus is idle-zero; the command exists only during the grant cycle.
  assign busy            = (state_q == ACCESS);
  assign c_gnt           = busy && (winner_q == PORT_C);
  assign d_gnt           = busy && (winner_q == PORT_D);
  assign sram_write_en   = busy && we_q;
  assign sram_addr       = busy ? addr_q  : '0;
  assign sram_write_data = busy ? wdata_q : '0;
  assign c_rvalid        = c_rvalid_q;
  assign d_rvalid        = d_rvalid_q;
  assign c_rdata         = c_rdata_q;
  assign d_rdata         = d_rdata_q;

  // A request must stay up until its grant; C is exempt while bootstrapping ignores it.
  c_req_held_a: assert property (@(posedge clk) disable iff (arst)
    (c_req && !c_gnt && !bootstrapping) |=> c_req);
  d_req_held_a: assert property (@(posedge clk) disable iff (arst)
    (d_req && !d_gnt) |=> d_req);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scenario bench for sram_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_sram_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int MAX_LOCK = 4;

  logic              clk = 1'b0;
  logic              arst;
  logic              bootstrapping;
  logic              c_req, c_we, c_gnt, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              sram_write_en, busy;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_write_data, sram_read_data;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .arst(arst), .bootstrapping(bootstrapping),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_write_en(sram_write_en), .sram_addr(sram_addr),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data),
    .busy(busy)
  );

  // Behavioural SRAM: asynchronous read, synchronous write, plus a backdoor preload port.
  logic [DATA_W-1:0] mem [0:255];
  logic              bd_we = 1'b0;
  logic [7:0]        bd_addr = '0;
  logic [7:0]        bd_data = '0;
  assign sram_read_data = mem[sram_addr];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (sram_write_en) mem[sram_addr] <= sram_write_data;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic c_prev = 1'b0;
  logic d_prev = 1'b0;
  int   log_q[$];
  int   log_t[$];
  int   tick_n = 0;

  task automatic tick();
    c_prev = c_gnt;
    d_prev = d_gnt;
    @(posedge clk);
    #1;
    tick_n++;
    if (c_gnt) begin log_q.push_back(0); log_t.push_back(tick_n); end
    if (d_gnt) begin log_q.push_back(1); log_t.push_back(tick_n); end
  endtask

  task automatic clear_log();
    log_q.delete();
    log_t.delete();
    tick_n = 0;
  endtask

  task automatic idle_inputs();
    bootstrapping = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    c_prev = 1'b0;
    d_prev = 1'b0;
    clear_log();
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  // Let every port finish its outstanding request, dropping req only after its grant.
  task automatic drain();
    int guard = 0;
    forever begin
      if (c_prev) c_req = 1'b0;
      if (d_prev) d_req = 1'b0;
      if (!c_req && !d_req && !busy) break;
      if (guard == 40) begin
        n_checks++; n_fail++;
        $display("FAIL drain: requests c=%0b d=%0b still pending after %0d cycles, want none",
                 c_req, d_req, guard);
        arst = 1'b1;
        c_req = 1'b0; d_req = 1'b0;
        break;
      end
      guard++;
      tick();
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if ({c_gnt, d_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {c_gnt, d_gnt}); end
    n_checks++;
    if ({c_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {c_rvalid, d_rvalid}); end
    n_checks++;
    if ({c_rdata, d_rdata} !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", {c_rdata, d_rdata}); end
    n_checks++;
    if ({sram_write_en, sram_addr, sram_write_data} !== 17'h0) begin
      n_fail++; $display("FAIL reset_sram_bus: got we=%b a=%h d=%h want all 0", sram_write_en, sram_addr, sram_write_data);
    end
    arst = 1'b0;
    clear_log();
    tick();
    n_checks++;
    if ({busy, c_gnt, d_gnt} !== 3'b000) begin n_fail++; $display("FAIL reset_idle: got busy/gnt %b want 000", {busy, c_gnt, d_gnt}); end
  endtask

  task automatic test_c_read();
    do_reset();
    preload(8'h12, 8'hA5);
    clear_log();
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h12;
    tick();
    n_checks++;
    if ({c_gnt, d_gnt, busy} !== 3'b101) begin n_fail++; $display("FAIL c_read_gnt: got c/d/busy %b want 101", {c_gnt, d_gnt, busy}); end
    n_checks++;
    if ({sram_write_en, sram_addr} !== {1'b0, 8'h12}) begin
      n_fail++; $display("FAIL c_read_bus: got we=%b a=%h want we=0 a=12", sram_write_en, sram_addr);
    end
    tick();
    c_req = 1'b0;
    n_checks++;
    if ({c_rvalid, c_rdata} !== {1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL c_read_data: got rvalid=%b rdata=%h want 1/a5", c_rvalid, c_rdata);
    end
    n_checks++;
    if ({c_gnt, d_gnt, d_rvalid, d_rdata} !== 11'h0) begin
      n_fail++; $display("FAIL c_read_d_quiet: got d_gnt=%b d_rvalid=%b d_rdata=%h c_gnt=%b want 0", d_gnt, d_rvalid, d_rdata, c_gnt);
    end
    tick();
    n_checks++;
    if ({c_rvalid, c_rdata} !== {1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL c_read_hold: got rvalid=%b rdata=%h want 0/a5", c_rvalid, c_rdata);
    end
  endtask

  task automatic test_sim_writes();
    int rv = 0;
    do_reset();
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h01; c_wdata = 8'h11;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h02; d_wdata = 8'h22;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (c_prev) c_req = 1'b0;
      if (d_prev) d_req = 1'b0;
      if (c_rvalid || d_rvalid) rv++;
      if (c_gnt) begin
        n_checks++;
        if ({sram_write_en, sram_addr, sram_write_data} !== {1'b1, 8'h01, 8'h11}) begin
          n_fail++; $display("FAIL wr_c_bus: got we=%b a=%h d=%h want 1/01/11", sram_write_en, sram_addr, sram_write_data);
        end
      end
      if (d_gnt) begin
        n_checks++;
        if ({sram_write_en, sram_addr, sram_write_data} !== {1'b1, 8'h02, 8'h22}) begin
          n_fail++; $display("FAIL wr_d_bus: got we=%b a=%h d=%h want 1/02/22", sram_write_en, sram_addr, sram_write_data);
        end
      end
    end
    n_checks++;
    if (log_q.size() != 2 || log_q[0] != 0 || log_t[0] != 1 || log_q[1] != 1 || log_t[1] != 3) begin
      n_fail++; $display("FAIL wr_order: got %0d grants (first port %0d @%0d, second port %0d @%0d) want C@1 then D@3",
                         log_q.size(), log_q[0], log_t[0], log_q[1], log_t[1]);
    end
    n_checks++;
    if (rv != 0) begin n_fail++; $display("FAIL wr_no_rvalid: got %0d rvalid cycles want 0", rv); end
    n_checks++;
    if ({mem[1], mem[2]} !== 16'h1122) begin n_fail++; $display("FAIL wr_mem: got %h %h want 11 22", mem[1], mem[2]); end
  endtask

  task automatic test_round_robin();
    logic [15:0] seq = '0;
    do_reset();
    c_req = 1'b1; c_addr = 8'h12;
    d_req = 1'b1; d_addr = 8'h12;
    repeat (8) tick();
    foreach (log_q[i]) seq = {seq[14:0], 1'(log_q[i])};
    n_checks++;
    if (log_q.size() != 4 || seq[3:0] !== 4'b0101) begin
      n_fail++; $display("FAIL rr_sequence: got %0d grants pattern %b want 4 grants 0101 (C=0 D=1)", log_q.size(), seq[3:0]);
    end
    n_checks++;
    if (log_t[0] != 1 || log_t[1] != 3 || log_t[2] != 5 || log_t[3] != 7) begin
      n_fail++; $display("FAIL rr_timing: got grants at %0d,%0d,%0d,%0d want 1,3,5,7", log_t[0], log_t[1], log_t[2], log_t[3]);
    end
    drain();
  endtask

  task automatic test_lock();
    logic [15:0] seq = '0;
    int guard = 0;
    do_reset();
    c_req = 1'b1; c_addr = 8'h12;
    d_req = 1'b1; d_addr = 8'h12;
    tick();
    // Lock is raised only once C holds the last grant, so the first tie is a plain one.
    d_lock = 1'b1;
    while (log_q.size() < 10 && guard < 40) begin
      tick();
      guard++;
    end
    foreach (log_q[i]) if (i < 10) seq = {seq[14:0], 1'(log_q[i])};
    n_checks++;
    if (log_q.size() < 10) begin n_fail++; $display("FAIL lock_timeout: got %0d grants want 10", log_q.size()); end
    n_checks++;
    if (seq[9:0] !== 10'b0111101111) begin
      n_fail++; $display("FAIL lock_sequence: got %b want 0111101111 (C=0 D=1)", seq[9:0]);
    end
    d_lock = 1'b0;
    drain();
  endtask

  task automatic test_bootstrap();
    int c_seen = 0;
    int d_seen = 0;
    int rv = 0;
    do_reset();
    bootstrapping = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h12;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 8'h77;
    repeat (8) begin
      tick();
      if (c_gnt) c_seen++;
      if (d_gnt) d_seen++;
      if (c_rvalid) rv++;
    end
    n_checks++;
    if (c_seen != 0 || d_seen != 4) begin
      n_fail++; $display("FAIL boot_grants: got c=%0d d=%0d want c=0 d=4", c_seen, d_seen);
    end
    n_checks++;
    if (rv != 0) begin n_fail++; $display("FAIL boot_c_rvalid: got %0d want 0", rv); end
    bootstrapping = 1'b0;
    tick();
    n_checks++;
    if ({c_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL boot_release: got c/d gnt %b want 10", {c_gnt, d_gnt}); end
    drain();
  endtask

  task automatic test_reset_mid_access();
    int rv = 0;
    do_reset();
    preload(8'h40, 8'h5A);
    clear_log();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
    tick();
    n_checks++;
    if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_pre_gnt: got d_gnt=%b want 1", d_gnt); end
    arst = 1'b1;
    #1;
    n_checks++;
    if ({d_gnt, busy, sram_write_en, sram_addr} !== 11'h0) begin
      n_fail++; $display("FAIL mid_abort: got d_gnt=%b busy=%b we=%b a=%h want all 0", d_gnt, busy, sram_write_en, sram_addr);
    end
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    c_prev = 1'b0;
    d_prev = 1'b0;
    repeat (3) begin
      tick();
      if (d_rvalid !== 1'b0 || d_rdata !== 8'h00) rv++;
    end
    n_checks++;
    if (rv != 0) begin n_fail++; $display("FAIL mid_no_rvalid: got %0d cycles with d_rvalid/d_rdata set want 0", rv); end
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h12;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
    tick();
    n_checks++;
    if ({c_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL mid_first_tie: got c/d gnt %b want 10", {c_gnt, d_gnt}); end
    drain();
  endtask

  // Transaction-level model: one decision per free slot, access completes one cycle later.
  task automatic test_random();
    logic [7:0] exp_mem [0:15];
    logic       m_busy, m_win, m_we, m_last, m_crv, m_drv, ec, ed, lk;
    logic [7:0] m_addr, m_wdata, m_crd, m_drd, v;
    int         m_cnt;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      preload(8'(i), v);
      exp_mem[i] = v;
    end
    m_busy = 1'b0; m_win = 1'b0; m_we = 1'b0; m_last = 1'b1; m_cnt = 0;
    m_addr = '0; m_wdata = '0; m_crv = 1'b0; m_drv = 1'b0; m_crd = '0; m_drd = '0;
    for (int k = 0; k < 400; k++) begin
      if (c_prev || !c_req) begin
        c_req = 1'($urandom_range(0, 1));
        c_we = 1'($urandom); c_addr = 8'($urandom_range(0, 15)); c_wdata = 8'($urandom);
      end
      if (d_prev || !d_req) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom); d_addr = 8'($urandom_range(0, 15)); d_wdata = 8'($urandom);
      end
      d_lock = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) bootstrapping = ~bootstrapping;

      m_crv = 1'b0;
      m_drv = 1'b0;
      if (m_busy) begin
        if (m_we) exp_mem[m_addr[3:0]] = m_wdata;
        else if (m_win == 1'b0) begin m_crv = 1'b1; m_crd = exp_mem[m_addr[3:0]]; end
        else begin m_drv = 1'b1; m_drd = exp_mem[m_addr[3:0]]; end
        m_last = m_win;
        m_busy = 1'b0;
      end else begin
        ec = c_req && !bootstrapping;
        ed = d_req;
        lk = m_last && d_lock && d_req && (m_cnt < MAX_LOCK);
        if (ec || ed) begin
          m_win = (ec && ed) ? (lk ? 1'b1 : ~m_last) : ed;
          if (m_win == 1'b0) m_cnt = 0;
          else if (ec) m_cnt = m_cnt + 1;
          m_we    = m_win ? d_we    : c_we;
          m_addr  = m_win ? d_addr  : c_addr;
          m_wdata = m_win ? d_wdata : c_wdata;
          m_busy  = 1'b1;
        end
      end
      if (bootstrapping || !d_lock) m_cnt = 0;

      tick();
      n_checks++;
      if ({c_gnt, d_gnt, busy} !== {m_busy && !m_win, m_busy && m_win, m_busy}) begin
        n_fail++; $display("FAIL rand_gnt cyc %0d: got c/d/busy %b want %b", k, {c_gnt, d_gnt, busy},
                           {m_busy && !m_win, m_busy && m_win, m_busy});
      end
      n_checks++;
      if ({sram_write_en, sram_addr, sram_write_data} !== (m_busy ? {m_we, m_addr, m_wdata} : 17'h0)) begin
        n_fail++; $display("FAIL rand_bus cyc %0d: got we=%b a=%h d=%h want busy=%b we=%b a=%h d=%h", k,
                           sram_write_en, sram_addr, sram_write_data, m_busy, m_we, m_addr, m_wdata);
      end
      n_checks++;
      if ({c_rvalid, d_rvalid} !== {m_crv, m_drv}) begin
        n_fail++; $display("FAIL rand_rvalid cyc %0d: got %b want %b", k, {c_rvalid, d_rvalid}, {m_crv, m_drv});
      end
      n_checks++;
      if ({c_rdata, d_rdata} !== {m_crd, m_drd}) begin
        n_fail++; $display("FAIL rand_rdata cyc %0d: got c=%h d=%h want c=%h d=%h", k, c_rdata, d_rdata, m_crd, m_drd);
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_c_read();
    test_sim_writes();
    test_round_robin();
    test_lock();
    test_bootstrap();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port 8-bit data SRAM between two requesters: the CPU control unit (port C) and a debug/boot loader master (port D).
- Registered request/grant handshake; the SRAM command is driven only in the grant cycle.
- Round-robin fairness, an optional bounded lock for port D bursts, and a bootstrap override that excludes the CPU.
- Sits between the control unit and the SRAM macro.

Parameters:
- ADDR_W, 8, SRAM address width
- DATA_W, 8, SRAM data width
- MAX_LOCK, 4, max consecutive D grants under dbg_lock while C is waiting (range 1..15)

Ports:
- clk  in  1  system clock
- arst  in  1  reset, asynchronous, active-high
- bootstrapping  in  1  high: C requests ignored, D owns SRAM
- c_req  in  1  C access request; hold with c_we/c_addr/c_wdata stable until c_gnt
- c_we  in  1  1 = write, 0 = read
- c_addr  in  ADDR_W  C address
- c_wdata  in  DATA_W  C write data
- c_gnt  out  1  one-cycle pulse: C access performed this cycle
- c_rvalid  out  1  one-cycle pulse: c_rdata valid
- c_rdata  out  DATA_W  read data for C
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  same as C
- d_lock  in  1  request to keep ownership across consecutive D accesses
- d_gnt, d_rvalid  out  1  same as C
- d_rdata  out  DATA_W  same as C
- sram_write_en  out  1  SRAM write strobe
- sram_addr  out  ADDR_W  SRAM address
- sram_write_data  out  DATA_W  SRAM write data
- sram_read_data  in  DATA_W  SRAM asynchronous read data
- busy  out  1  high in the ACCESS state

Behaviour:
- Reset (arst=1, async) sets state=IDLE, last_winner=D, lock_cnt=0, and all outputs to 0 (including rdata). An in-flight access is dropped and no rvalid is issued.

FSM:
- IDLE: sample eligible requests. eligible_c = c_req & ~bootstrapping; eligible_d = d_req. If any is eligible, register winner, we, addr, wdata, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle): drive sram_addr/sram_write_en/sram_write_data from the registered copies and pulse the winner's gnt. For a read, capture sram_read_data into the winner's rdata at the clock edge. Set last_winner=winner and go to IDLE.
- Outside ACCESS: sram_write_en=0, sram_addr=0, sram_write_data=0.

Timing:
- Request sampled in IDLE at cycle N: gnt in N+1, rvalid and rdata in N+2.
- Peak throughput is one access per 2 cycles.
- Writes never produce rvalid.
- rdata holds its last value until the next read for that port.
- A requester sees gnt and may change or drop req in the cycle after gnt. A req still high in that cycle (IDLE) is a new request.

Arbitration in IDLE:
- Only one eligible: that port wins.
- Both eligible: the port that is not last_winner wins, unless lock is active.
- Lock active when: last_winner=D, d_lock=1, d_req=1, and lock_cnt<MAX_LOCK. While active, D wins over C.
- lock_cnt increments on each D grant made while C was eligible and lost.
- lock_cnt clears on any C grant or when d_lock=0.
- When lock_cnt==MAX_LOCK and C is eligible, C wins once.
- bootstrapping=1: C is never granted and lock_cnt is held at 0. Rising bootstrapping during ACCESS for C still completes that access.
- req dropped before gnt is a protocol violation; behaviour is undefined and covered by an assertion.

Decomposition:
- Shared package sram_arb_pkg holds the state encodings (IDLE=1'b0, ACCESS=1'b1) and the port IDs (PORT_C=1'b0, PORT_D=1'b1).
- One sub-module, rr_lock_picker: combinational winner select from eligible_c, eligible_d, last_winner, lock condition.
- The FSM, lock counter and datapath registers stay in sram_arbiter.

Test Plan:
1. C read only: c_req=1, c_we=0, c_addr=0x12, SRAM[0x12]=0xA5 -> c_gnt at N+1 with sram_addr=0x12; c_rvalid=1 and c_rdata=0xA5 at N+2; d_* quiet.
2. Simultaneous writes after reset: C (0x01←0x11) and D (0x02←0x22) held high -> C granted first, then D two cycles later; SRAM[0x01]=0x11, SRAM[0x02]=0x22; no rvalid.
3. Round-robin: both request continuously for 8 cycles, no lock -> grants alternate C,D,C,D; 4 grants total.
4. Lock bound: d_lock=1, D and C requesting continuously, MAX_LOCK=4 -> one C grant (tie, after reset), then 4 D grants, then 1 C grant, then 4 D grants.
5. Bootstrapping: bootstrapping=1, c_req and d_req high -> only D grants; c_gnt never asserts; drop bootstrapping -> next tie grants C.
6. Reset mid-access: assert arst in the ACCESS cycle of a D read -> sram_write_en=0, d_gnt=0, busy=0 immediately; no d_rvalid after release; first post-reset tie goes to C.
